// File: rtl/ring_nic.sv
// PE-side network interface for a ring router: memory-mapped in/out buffers plus the send/ready link.
// Optional macro NIC_PKT_CNT_EN adds 32-bit tx/rx packet counters to the status registers.
module ring_nic #(
  parameter int PAC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           addr,
  input  logic [PAC_WIDTH-1:0] d_in,
  output logic [PAC_WIDTH-1:0] d_out,
  input  logic                 nicEn,
  input  logic                 nicWrEn,
  output logic                 net_so,
  input  logic                 net_ro,
  output logic [PAC_WIDTH-1:0] net_do,
  input  logic                 net_polarity,
  input  logic                 net_si,
  output logic                 net_ri,
  input  logic [PAC_WIDTH-1:0] net_di
);

  logic [PAC_WIDTH-1:0] out_buf_r;
  logic [PAC_WIDTH-1:0] in_buf_r;
  logic                 out_full_r;
  logic                 in_full_r;
  logic                 eligible_s;
  logic                 accept_s;
  logic                 rd_s;
  logic                 wr_s;
  logic [PAC_WIDTH-1:0] in_status_s;
  logic [PAC_WIDTH-1:0] out_status_s;

`ifdef NIC_PKT_CNT_EN
  logic [31:0] tx_cnt_r;
  logic [31:0] rx_cnt_r;
`endif

  // Link handshake, access decode and status word assembly.
  always_comb begin
    // The vc bit must match the inverted router polarity before a packet may leave.
    eligible_s = out_full_r && net_ro && (out_buf_r[PAC_WIDTH-1] == ~net_polarity);
    accept_s   = net_si && !in_full_r;
    rd_s       = nicEn && !nicWrEn;
    wr_s       = nicEn && nicWrEn && (addr == 2'b10);
    net_so     = eligible_s;
    net_ri     = ~in_full_r;
    if (eligible_s) begin
      net_do = out_buf_r;
    end else begin
      net_do = {PAC_WIDTH{1'b0}};
    end
`ifdef NIC_PKT_CNT_EN
    in_status_s  = {rx_cnt_r, {(PAC_WIDTH-33){1'b0}}, in_full_r};
    out_status_s = {tx_cnt_r, {(PAC_WIDTH-33){1'b0}}, out_full_r};
`else
    in_status_s  = {{(PAC_WIDTH-1){1'b0}}, in_full_r};
    out_status_s = {{(PAC_WIDTH-1){1'b0}}, out_full_r};
`endif
  end

  // Buffer state and registered PE read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf_r  <= {PAC_WIDTH{1'b0}};
      out_full_r <= 1'b0;
      in_buf_r   <= {PAC_WIDTH{1'b0}};
      in_full_r  <= 1'b0;
      d_out      <= {PAC_WIDTH{1'b0}};
    end else begin
      // A completing injection blocks a same-cycle PE write since out_full was still set.
      if (eligible_s) begin
        out_full_r <= 1'b0;
      end else if (wr_s && !out_full_r) begin
        out_buf_r  <= d_in;
        out_full_r <= 1'b1;
      end
      // An arrival only happens while empty, so it can never race a clearing read.
      if (accept_s) begin
        in_buf_r  <= net_di;
        in_full_r <= 1'b1;
      end else if (rd_s && (addr == 2'b00)) begin
        in_full_r <= 1'b0;
      end
      if (rd_s) begin
        case (addr)
          2'b00:   d_out <= in_buf_r;
          2'b01:   d_out <= in_status_s;
          2'b10:   d_out <= {PAC_WIDTH{1'b0}};
          2'b11:   d_out <= out_status_s;
          default: d_out <= {PAC_WIDTH{1'b0}};
        endcase
      end
    end
  end

`ifdef NIC_PKT_CNT_EN
  // Wrapping packet counters for completed injections and accepted ejections.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_r <= 32'd0;
      rx_cnt_r <= 32'd0;
    end else begin
      if (eligible_s) begin
        tx_cnt_r <= tx_cnt_r + 32'd1;
      end
      if (accept_s) begin
        rx_cnt_r <= rx_cnt_r + 32'd1;
      end
    end
  end
`endif

endmodule
